pulse_seq: RTL and testbench
============================

Name: pulse_seq

Overview:
- Parametrised successor of the fixed 8-phase pulse distributor (РИ).
- Steps a one-hot phase ring of N_PHASE phases. Each phase can be gated by an operator/IO start pulse, a memory-read handshake, or skipped entirely, all under per-phase masks driven by op decode.
- Adds a memory-reply watchdog and a halt/error state.
- Sits between op (masks in, operate pulse out), mem (read request/reply) and pnl (clear, state display).

Parameters:
- N_PHASE, 8, number of phases in the ring (2..16).
- PW, $clog2(N_PHASE), width of the phase index.
- TIMEOUT, 255, maximum cycles spent waiting for a mem reply before halting (1..65535).
- TW, 16, width of the watchdog counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- clear_pu_from_pnl  in  1  pulse; synchronous return to phase 0, clears error
- start_pulse_from_io  in  1  pulse; releases phases that wait for start
- mem_read_reply_from_mem  in  1  pulse; read data valid
- wait_start_mask_from_op  in  N_PHASE  level; bit p set means phase p waits for start
- mem_read_mask_from_op  in  N_PHASE  level; bit p set means phase p performs a mem read
- skip_mask_from_op  in  N_PHASE  level; bit p set means phase p is skipped (bit 0 ignored)
- at_phase  out  N_PHASE  level, one-hot current phase
- entering_phase  out  N_PHASE  pulse; bit q high in the cycle the ring advances into q
- mem_read_to_mem  out  1  pulse; read request
- mem_accept  out  1  pulse; reply accepted (gates mem-to-C loads downstream)
- operate_pulse_to_op  out  1  pulse; high whenever at phase N_PHASE-1
- cycle_done  out  1  pulse; advance from the last active phase back to 0
- timeout_err_to_pnl  out  1  level; sticky watchdog error
- pu_state_to_pnl  out  PW  current phase index

Behaviour:
- Reset (resetn=0 at posedge):
  - phase=0, state=RUN.
  - at_phase=1, all pulses 0, timeout_err=0, watchdog=0, outstanding=0, reply_seen=0.
- Precedence: reset > clear > normal operation. Clear behaves exactly like reset, mid-wait included. A reply arriving in the clear cycle is dropped.
- FSM:
  - RUN → WAIT_MEM on a mem-read phase entry.
  - WAIT_MEM → RUN on accept.
  - WAIT_MEM → HALT when the watchdog reaches TIMEOUT.
  - HALT holds until clear or reset. In HALT all pulses are 0 and the phase is frozen.
- Entry cycle of phase p (first cycle with at_phase[p]): if mem_read_mask[p], then mem_read_to_mem=1 for exactly that cycle, outstanding=1, watchdog=0. Masks for a phase are sampled in its entry cycle and held until exit.
- Reply handling:
  - mem_accept = reply && outstanding. It clears outstanding and sets reply_seen.
  - A reply with outstanding=0 is ignored.
  - The earliest accepted reply is the cycle after the request.
- Advance condition at p: mem_ok && start_ok.
  - mem_ok = !mem_read_mask[p] || reply_seen || mem_accept.
  - start_ok = !wait_start_mask[p] || start_pulse_from_io.
  - A start pulse arriving before mem_ok is lost; the phase waits for a later start.
- Next phase: the first q after p, taken modulo N_PHASE, with skip_mask[q]=0. Phase 0 is never skipped. On advance, entering_phase[q]=1 in the same cycle and the registered phase becomes q on the next edge. reply_seen clears on advance.
- Watchdog: increments each WAIT_MEM cycle without accept and saturates. When it equals TIMEOUT: state=HALT, timeout_err=1, outstanding=0.
- A phase with neither mask set advances every cycle, so minimum one cycle per phase.

Optional Feature:
- Macro: PULSE_SEQ_STEP_EN.
- Defined: adds input step_mode_from_pnl (1 bit). While it is high, every phase behaves as if wait_start_mask=all ones (single-step via start).
- Undefined: the port is absent and the masks alone govern.

Decomposition:
- Shared package pulse_seq_pkg:
  - state enum {RUN, WAIT_MEM, HALT}
  - default N_PHASE/TIMEOUT constants
  - function next_active(idx, skip_mask)
- Sub-module pulse_seq_wdog: the saturating watchdog counter with clear/enable/hit.

Test Plan:
- All masks 0 → phases 0..7 each last one cycle. entering_phase[1] one cycle after reset release. cycle_done every 8 cycles. operate_pulse when pu_state=7.
- wait_start_mask=8'h05, start at cycles 3 and 10 → holds in phase 0 until cycle 3, then in phase 2 until cycle 10.
- mem_read_mask=8'h02, reply 4 cycles after request → single mem_read_to_mem pulse, mem_accept once, phase 1 exits in the reply cycle. A spurious reply in phase 3 is ignored.
- skip_mask=8'hF0 → ring 0,1,2,3,0. cycle_done fires on the 3→0 advance.
- TIMEOUT=10, mem read with no reply → HALT after 10 wait cycles, timeout_err=1, outputs frozen. clear_pu_from_pnl → phase 0, err 0.
- Reset asserted mid WAIT_MEM with a reply in the same cycle → phase 0, no mem_accept, outstanding=0.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Shared types, defaults and next-phase helper for the pulse_seq phase ring.
package pulse_seq_pkg;

  typedef enum logic [1:0] {RUN, WAIT_MEM, HALT} state_e;

  localparam int unsigned DEF_N_PHASE = 8;
  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned MAX_PHASE   = 16;

  // First phase after idx (mod n_phase) whose skip bit is clear; phase 0 always qualifies.
  function automatic logic [3:0] next_active(input logic [3:0]  idx,
                                             input logic [15:0] skip_mask,
                                             input int unsigned n_phase);
    logic [3:0]  res;
    logic        found;
    int unsigned q;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_PHASE; k++) begin
      q = 32'(idx) + k;
      if (q >= n_phase) q = q - n_phase;
      if (!found && k <= n_phase && (q == 0 || !skip_mask[q[3:0]])) begin
        res   = q[3:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pulse_seq_wdog.sv
// Saturating memory-reply watchdog; hit fires in the cycle the count reaches TIMEOUT.
module pulse_seq_wdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [TW-1:0] cnt_q, cnt_d, cnt_inc;

  always_comb begin
    cnt_inc = cnt_q + TW'(1);
    cnt_d   = cnt_q;
    hit     = en && (cnt_inc == TW'(TIMEOUT));
    if (clr)                   cnt_d = '0;
    else if (en && cnt_q != '1) cnt_d = cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pulse_seq.sv
// One-hot phase ring with start/mem-read gating, skip masks, reply watchdog and halt.
// Optional PULSE_SEQ_STEP_EN adds step_mode_from_pnl (every phase waits for start).
module pulse_seq
  import pulse_seq_pkg::*;
#(
  parameter int unsigned N_PHASE = DEF_N_PHASE,
  parameter int unsigned PW      = $clog2(N_PHASE),
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned TW      = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear_pu_from_pnl,
  input  logic               start_pulse_from_io,
  input  logic               mem_read_reply_from_mem,
`ifdef PULSE_SEQ_STEP_EN
  input  logic               step_mode_from_pnl,
`endif
  input  logic [N_PHASE-1:0] wait_start_mask_from_op,
  input  logic [N_PHASE-1:0] mem_read_mask_from_op,
  input  logic [N_PHASE-1:0] skip_mask_from_op,
  output logic [N_PHASE-1:0] at_phase,
  output logic [N_PHASE-1:0] entering_phase,
  output logic               mem_read_to_mem,
  output logic               mem_accept,
  output logic               operate_pulse_to_op,
  output logic               cycle_done,
  output logic               timeout_err_to_pnl,
  output logic [PW-1:0]      pu_state_to_pnl
);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d, nxt;
  logic          entry_q, entry_d;
  logic          wait_hold_q, wait_hold_d;
  logic          read_hold_q, read_hold_d;
  logic          outstanding_q, outstanding_d;
  logic          reply_seen_q, reply_seen_d;
  logic          err_q, err_d;
  logic          step_mode, active, wait_eff, read_eff, mem_req, accept;
  logic          mem_ok, start_ok, advance, wd_clr, wd_en, wd_hit;

`ifdef PULSE_SEQ_STEP_EN
  assign step_mode = step_mode_from_pnl;
`else
  assign step_mode = 1'b0;
`endif

  pulse_seq_wdog #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wdog (
    .clk    (clk),
    .resetn (resetn),
    .clr    (wd_clr),
    .en     (wd_en),
    .hit    (wd_hit)
  );

  // Masks are live in the entry cycle and taken from the hold flops afterwards.
  always_comb begin
    active   = resetn && !clear_pu_from_pnl && (state_q != HALT);
    wait_eff = (entry_q ? wait_start_mask_from_op[phase_q] : wait_hold_q) | step_mode;
    read_eff = entry_q ? mem_read_mask_from_op[phase_q] : read_hold_q;
    mem_req  = active && entry_q && read_eff;
    accept   = active && mem_read_reply_from_mem && outstanding_q;
    mem_ok   = !read_eff || reply_seen_q || accept;
    start_ok = !wait_eff || start_pulse_from_io;
    advance  = active && mem_ok && start_ok;
    nxt      = PW'(next_active(4'(phase_q), 16'(skip_mask_from_op), N_PHASE));
    wd_clr   = clear_pu_from_pnl || mem_req;
    wd_en    = active && (state_q == WAIT_MEM) && !accept;
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    entry_d       = entry_q;
    wait_hold_d   = wait_hold_q;
    read_hold_d   = read_hold_q;
    outstanding_d = outstanding_q;
    reply_seen_d  = reply_seen_q;
    err_d         = err_q;
    if (clear_pu_from_pnl) begin
      state_d       = RUN;
      phase_d       = '0;
      entry_d       = 1'b1;
      wait_hold_d   = 1'b0;
      read_hold_d   = 1'b0;
      outstanding_d = 1'b0;
      reply_seen_d  = 1'b0;
      err_d         = 1'b0;
    end else if (state_q != HALT) begin
      if (entry_q) begin
        entry_d     = 1'b0;
        wait_hold_d = wait_start_mask_from_op[phase_q];
        read_hold_d = mem_read_mask_from_op[phase_q];
      end
      if (mem_req) begin
        outstanding_d = 1'b1;
        state_d       = WAIT_MEM;
      end
      if (accept) begin
        outstanding_d = 1'b0;
        reply_seen_d  = 1'b1;
        state_d       = RUN;
      end
      if (wd_hit) begin
        outstanding_d = 1'b0;
        err_d         = 1'b1;
        state_d       = HALT;
      end
      if (advance) begin
        phase_d      = nxt;
        entry_d      = 1'b1;
        reply_seen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= RUN;
      phase_q       <= '0;
      entry_q       <= 1'b1;
      wait_hold_q   <= 1'b0;
      read_hold_q   <= 1'b0;
      outstanding_q <= 1'b0;
      reply_seen_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      entry_q       <= entry_d;
      wait_hold_q   <= wait_hold_d;
      read_hold_q   <= read_hold_d;
      outstanding_q <= outstanding_d;
      reply_seen_q  <= reply_seen_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    at_phase                = '0;
    at_phase[phase_q]       = 1'b1;
    entering_phase          = '0;
    if (advance) entering_phase[nxt] = 1'b1;
    mem_read_to_mem         = mem_req;
    mem_accept              = accept;
    operate_pulse_to_op     = active && (phase_q == PW'(N_PHASE - 1));
    cycle_done              = advance && (nxt == '0);
    timeout_err_to_pnl      = err_q;
    pu_state_to_pnl         = phase_q;
  end

endmodule

// File: tb/tb_pulse_seq.sv
// Directed bench for pulse_seq: per-cycle expected output snapshots via a scoreboard queue.
module tb_pulse_seq;

  logic       clk = 1'b0;
  logic       resetn, clear, start, reply;
  logic [7:0] wmask, rmask, smask;
  logic [7:0] at_phase, entering_phase;
  logic       mem_read, mem_accept, operate, cycle_done, err;
  logic [2:0] pu_state;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] at;
    logic [7:0] ent;
    logic       rd;
    logic       acc;
    logic       op;
    logic       done;
    logic       err;
    logic [2:0] st;
  } snap_t;

  snap_t exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  pulse_seq #(.N_PHASE(8), .TIMEOUT(10), .TW(16)) dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .clear_pu_from_pnl       (clear),
    .start_pulse_from_io     (start),
    .mem_read_reply_from_mem (reply),
`ifdef PULSE_SEQ_STEP_EN
    .step_mode_from_pnl      (1'b0),
`endif
    .wait_start_mask_from_op (wmask),
    .mem_read_mask_from_op   (rmask),
    .skip_mask_from_op       (smask),
    .at_phase                (at_phase),
    .entering_phase          (entering_phase),
    .mem_read_to_mem         (mem_read),
    .mem_accept              (mem_accept),
    .operate_pulse_to_op     (operate),
    .cycle_done              (cycle_done),
    .timeout_err_to_pnl      (err),
    .pu_state_to_pnl         (pu_state)
  );

  // Expected snapshot: phase ph, advancing into nx (-1 = no advance); gated = reset/clear/halt cycle.
  function automatic snap_t mk(input int ph, input int nx, input bit rd, input bit acc,
                               input bit e, input bit gated);
    snap_t s;
    s.at   = 8'd1 << ph;
    s.ent  = (nx >= 0) ? (8'd1 << nx) : 8'd0;
    s.rd   = rd;
    s.acc  = acc;
    s.op   = (ph == 7) && !gated;
    s.done = (nx == 0);
    s.err  = e;
    s.st   = 3'(ph);
    return s;
  endfunction

  task automatic check_out();
    snap_t obs, e;
    string t;
    obs = {at_phase, entering_phase, mem_read, mem_accept, operate, cycle_done, err, pu_state};
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic cyc(input string tag, input snap_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; clear = 1'b0; start = 1'b0; reply = 1'b0;
    wmask = '0; rmask = '0; smask = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", mk(0, -1, 0, 0, 0, 1));
    resetn = 1'b1;

    // free-running ring, one cycle per phase
    for (int i = 0; i < 16; i++) cyc("ring", mk(i % 8, (i + 1) % 8, 0, 0, 0, 0));

    // wait-for-start on phases 0 and 2
    clear = 1'b1; wmask = 8'h05;
    cyc("clr_ws", mk(0, -1, 0, 0, 0, 1));
    clear = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ws_hold0", mk(0, -1, 0, 0, 0, 0));
    start = 1'b1; cyc("ws_go0", mk(0, 1, 0, 0, 0, 0)); start = 1'b0;
    cyc("ws_p1", mk(1, 2, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) cyc("ws_hold2", mk(2, -1, 0, 0, 0, 0));
    start = 1'b1; cyc("ws_go2", mk(2, 3, 0, 0, 0, 0)); start = 1'b0;
    for (int p = 3; p < 8; p++) cyc("ws_run", mk(p, (p + 1) % 8, 0, 0, 0, 0));
    cyc("ws_hold0b", mk(0, -1, 0, 0, 0, 0));

    // mem read on phase 1, reply 4 cycles after request, spurious reply in phase 3
    clear = 1'b1; wmask = '0; rmask = 8'h02;
    cyc("clr_mr", mk(0, -1, 0, 0, 0, 1));
    clear = 1'b0;
    cyc("mr_p0", mk(0, 1, 0, 0, 0, 0));
    cyc("mr_req", mk(1, -1, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc("mr_wait", mk(1, -1, 0, 0, 0, 0));
    reply = 1'b1; cyc("mr_acc", mk(1, 2, 0, 1, 0, 0)); reply = 1'b0;
    cyc("mr_p2", mk(2, 3, 0, 0, 0, 0));
    reply = 1'b1; cyc("mr_spur", mk(3, 4, 0, 0, 0, 0)); reply = 1'b0;
    for (int p = 4; p < 8; p++) cyc("mr_run", mk(p, (p + 1) % 8, 0, 0, 0, 0));
    cyc("mr_p0b", mk(0, 1, 0, 0, 0, 0));
    cyc("mr_req2", mk(1, -1, 1, 0, 0, 0));

    // skip phases 4..7, clear taken mid-wait
    clear = 1'b1; rmask = '0; smask = 8'hF0;
    cyc("clr_skip", mk(1, -1, 0, 0, 0, 1));
    clear = 1'b0;
    for (int i = 0; i < 8; i++) cyc("skip", mk(i % 4, (i + 1) % 4, 0, 0, 0, 0));

    // watchdog timeout after 10 wait cycles, then halt is frozen
    clear = 1'b1; smask = '0; rmask = 8'h02;
    cyc("clr_to", mk(0, -1, 0, 0, 0, 1));
    clear = 1'b0;
    cyc("to_p0", mk(0, 1, 0, 0, 0, 0));
    cyc("to_req", mk(1, -1, 1, 0, 0, 0));
    for (int i = 0; i < 10; i++) cyc("to_wait", mk(1, -1, 0, 0, 0, 0));
    reply = 1'b1; start = 1'b1;
    cyc("halt_a", mk(1, -1, 0, 0, 1, 1));
    cyc("halt_b", mk(1, -1, 0, 0, 1, 1));
    reply = 1'b0; start = 1'b0;
    clear = 1'b1;
    cyc("halt_clr", mk(1, -1, 0, 0, 1, 1));
    clear = 1'b0;

    // reset mid-wait with a reply in the same cycle
    cyc("rst_p0", mk(0, 1, 0, 0, 0, 0));
    cyc("rst_req", mk(1, -1, 1, 0, 0, 0));
    cyc("rst_wait", mk(1, -1, 0, 0, 0, 0));
    resetn = 1'b0; reply = 1'b1;
    cyc("rst_cyc", mk(1, -1, 0, 0, 0, 1));
    resetn = 1'b1;
    cyc("rst_noacc", mk(0, 1, 0, 0, 0, 0));
    reply = 1'b0;
    cyc("rst_req2", mk(1, -1, 1, 0, 0, 0));
    reply = 1'b1; cyc("rst_acc", mk(1, 2, 0, 1, 0, 0)); reply = 1'b0;
    cyc("rst_p2", mk(2, 3, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
